// File: rtl/isle_tmds_pkg.sv
// Shared constants and helpers for the DVI TMDS encoder.
package isle_tmds_pkg;

  localparam int TMDS_W     = 10;
  localparam int TMDS_CNT_W = 6;

  localparam logic [TMDS_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [TMDS_W-1:0] tmds_ctrl_sym(input logic [1:0] c);
    logic [TMDS_W-1:0] s;
    case (c)
      2'b00:   s = TMDS_CTRL_00;
      2'b01:   s = TMDS_CTRL_01;
      2'b10:   s = TMDS_CTRL_10;
      default: s = TMDS_CTRL_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_qm.sv
// TMDS stage A: transition-minimised q_m, its ones count, and the
// de/ctrl bits aligned with it.
module tmds_qm
  import isle_tmds_pkg::*;
(
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic       de,
  input  logic [7:0] d8,
  input  logic [1:0] ctrl,
  output logic       de_a,
  output logic [1:0] ctrl_a,
  output logic [8:0] q_m,
  output logic [3:0] n1q
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m_c;

  always_comb begin
    n1d      = popcount8(d8);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d8[0]);
    q_m_c    = '0;
    q_m_c[0] = d8[0];
    for (int i = 1; i < 8; i++) begin
      q_m_c[i] = use_xnor ? ~(q_m_c[i-1] ^ d8[i]) : (q_m_c[i-1] ^ d8[i]);
    end
    q_m_c[8] = ~use_xnor;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      de_a   <= 1'b0;
      ctrl_a <= 2'b00;
      q_m    <= '0;
      n1q    <= '0;
    end else begin
      de_a   <= de;
      ctrl_a <= ctrl;
      q_m    <= q_m_c;
      n1q    <= popcount8(q_m_c[7:0]);
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// Single-channel DVI TMDS encoder, 2-cycle latency, one symbol per clock,
// no handshake. ISLE_TMDS_EXPAND_EN selects a BPC-bit din with MSB replication.
module tmds_encoder
  import isle_tmds_pkg::*;
#(
  parameter int BPC = 5
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix_n,
  input  logic                  de,
`ifdef ISLE_TMDS_EXPAND_EN
  input  logic [BPC-1:0]        din,
`else
  input  logic [7:0]            din,
`endif
  input  logic [1:0]            ctrl,
  output logic [TMDS_W-1:0]     tmds,
  output logic [TMDS_CNT_W-1:0] disp
);

  if (BPC < 4 || BPC > 7) begin : g_bpc_bad
    $error("tmds_encoder: BPC must be in 4..7");
  end

  logic [7:0] d8;
`ifdef ISLE_TMDS_EXPAND_EN
  assign d8 = {din, din[BPC-1 -: 8-BPC]};
`else
  assign d8 = din;
`endif

  logic       de_a;
  logic [1:0] ctrl_a;
  logic [8:0] q_m;
  logic [3:0] n1q;

  tmds_qm u_qm (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .de        (de),
    .d8        (d8),
    .ctrl      (ctrl),
    .de_a      (de_a),
    .ctrl_a    (ctrl_a),
    .q_m       (q_m),
    .n1q       (n1q)
  );

  logic signed [TMDS_CNT_W-1:0] cnt, cnt_nx, n1s, diff, q8x2;
  logic [TMDS_W-1:0]            tmds_nx;
  logic                         q8;

  // diff = N1q - N0q = 2*N1q - 8, sign-extended into the counter width
  always_comb begin
    q8      = q_m[8];
    n1s     = $signed({2'b00, n1q});
    diff    = (n1s <<< 1) - 6'sd8;
    q8x2    = q8 ? 6'sd2 : 6'sd0;
    tmds_nx = tmds_ctrl_sym(ctrl_a);
    cnt_nx  = '0;
    if (de_a) begin
      if ((cnt == 6'sd0) || (n1q == 4'd4)) begin
        tmds_nx = {~q8, q8, (q8 ? q_m[7:0] : ~q_m[7:0])};
        cnt_nx  = q8 ? (cnt + diff) : (cnt - diff);
      end else if (((cnt > 6'sd0) && (n1q > 4'd4)) ||
                   ((cnt < 6'sd0) && (n1q < 4'd4))) begin
        tmds_nx = {1'b1, q8, ~q_m[7:0]};
        cnt_nx  = cnt + q8x2 - diff;
      end else begin
        tmds_nx = {1'b0, q8, q_m[7:0]};
        cnt_nx  = cnt + diff - (q8 ? 6'sd0 : 6'sd2);
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      tmds <= TMDS_CTRL_00;
      cnt  <= '0;
    end else begin
      tmds <= tmds_nx;
      cnt  <= cnt_nx;
    end
  end

  assign disp = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed-vector and reference-model bench for tmds_encoder.
module tb_tmds_encoder;
  import isle_tmds_pkg::*;

`ifdef ISLE_TMDS_EXPAND_EN
  localparam int DIN_W = 5;
`else
  localparam int DIN_W = 8;
`endif

  // clock / reset
  logic             clk_pix   = 1'b0;
  logic             rst_pix_n = 1'b1;
  logic             de        = 1'b0;
  logic [DIN_W-1:0] din       = '0;
  logic [1:0]       ctrl      = 2'b00;
  logic [9:0]       tmds;
  logic [5:0]       disp;

  always #5 clk_pix = ~clk_pix;

  tmds_encoder #(.BPC(5)) dut (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .de        (de),
    .din       (din),
    .ctrl      (ctrl),
    .tmds      (tmds),
    .disp      (disp)
  );

  typedef struct {
    logic       de;
    logic [7:0] din;
    logic [1:0] ctrl;
    logic [9:0] exp_tmds;
    int         exp_disp;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] exp_q[$];
  int         exp_disp_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         model_cnt = 0;

  // scoreboard checks
  task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: tmds got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] expand(input logic [DIN_W-1:0] d);
`ifdef ISLE_TMDS_EXPAND_EN
    return {d, d[DIN_W-1 -: 8-DIN_W]};
`else
    return d;
`endif
  endfunction

  // reference encoder straight from the DVI algorithm
  task automatic model_enc(input logic de_i, input logic [7:0] d, input logic [1:0] c,
                           output logic [9:0] sym);
    logic [8:0] qm;
    int n1, n1q, n0q;
    bit x;
    if (!de_i) begin
      model_cnt = 0;
      case (c)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      return;
    end
    n1 = $countones(d);
    x  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !x;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (model_cnt == 0 || n1q == n0q) begin
      sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      model_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((model_cnt > 0 && n1q > n0q) || (model_cnt < 0 && n0q > n1q)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      model_cnt += 2 * int'(qm[8]) + (n0q - n1q);
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      model_cnt += (n1q - n0q) - (qm[8] ? 0 : 2);
    end
  endtask

  // driver: apply one input, push its expectation, compare the symbol leaving the pipe
  task automatic step(input logic de_i, input logic [DIN_W-1:0] d_i, input logic [1:0] c_i,
                      input logic [9:0] exp_t, input int exp_d, input string name);
    logic [9:0] et;
    int         ed;
    de   = de_i;
    din  = d_i;
    ctrl = c_i;
    exp_q.push_back(exp_t);
    exp_disp_q.push_back(exp_d);
    @(posedge clk_pix);
    #1;
    et = exp_q.pop_front();
    ed = exp_disp_q.pop_front();
    check_sym({name, " sym"}, tmds, et);
    check_int({name, " disp"}, int'($signed(disp)), ed);
  endtask

  task automatic model_step(input logic de_i, input logic [DIN_W-1:0] d_i,
                            input logic [1:0] c_i, input string name);
    logic [9:0] s;
    model_enc(de_i, expand(d_i), c_i, s);
    step(de_i, d_i, c_i, s, model_cnt, name);
  endtask

  // reset asserted between edges; must take effect before the next edge
  task automatic do_reset();
    rst_pix_n = 1'b0;
    de   = 1'($urandom_range(0, 1));
    din  = DIN_W'($urandom_range(0, (1 << DIN_W) - 1));
    ctrl = 2'($urandom_range(0, 3));
    #2;
    check_sym("async reset", tmds, 10'b1101010100);
    check_int("async reset disp", int'($signed(disp)), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_pix);
      de   = 1'($urandom_range(0, 1));
      din  = DIN_W'($urandom_range(0, (1 << DIN_W) - 1));
      ctrl = 2'($urandom_range(0, 3));
      #1;
      check_sym("held reset", tmds, 10'b1101010100);
      check_int("held reset disp", int'($signed(disp)), 0);
    end
    @(posedge clk_pix);
    #1;
    de        = 1'b0;
    ctrl      = 2'b00;
    rst_pix_n = 1'b1;
    exp_q.delete();
    exp_disp_q.delete();
    exp_q.push_back(10'b1101010100);
    exp_disp_q.push_back(0);
    model_cnt = 0;
  endtask

  initial begin
    logic [9:0] s;
    logic [DIN_W-1:0] r;

`ifndef ISLE_TMDS_EXPAND_EN
    vecs = '{
      '{1'b0, 8'h00, 2'b00, 10'b1101010100,  0},
      '{1'b0, 8'h00, 2'b01, 10'b0010101011,  0},
      '{1'b0, 8'h00, 2'b10, 10'b0101010100,  0},
      '{1'b0, 8'h00, 2'b11, 10'b1010101011,  0},
      '{1'b1, 8'h00, 2'b00, 10'h100,        -8},
      '{1'b1, 8'h00, 2'b00, 10'h3FF,         2},
      '{1'b0, 8'h00, 2'b00, 10'b1101010100,  0},
      '{1'b1, 8'hFF, 2'b00, 10'h200,        -8},
      '{1'b0, 8'h00, 2'b00, 10'b1101010100,  0},
      '{1'b1, 8'h84, 2'b00, 10'h17C,         2},
      '{1'b1, 8'h55, 2'b00, 10'h133,         2},
      '{1'b1, 8'h10, 2'b00, 10'h1F0,         2},
      '{1'b1, 8'hF0, 2'b00, 10'h205,        -2},
      '{1'b1, 8'h01, 2'b00, 10'h1FF,         6},
      '{1'b1, 8'h00, 2'b00, 10'h100,        -2},
      '{1'b0, 8'h00, 2'b11, 10'b1010101011,  0}
    };
`else
    vecs = '{
      '{1'b0, 8'h00, 2'b00, 10'b1101010100,  0},
      '{1'b1, 8'h1F, 2'b00, 10'h200,        -8},
      '{1'b0, 8'h00, 2'b00, 10'b1101010100,  0},
      '{1'b1, 8'h10, 2'b00, 10'h17C,         2},
      '{1'b1, 8'h00, 2'b00, 10'h100,        -6},
      '{1'b0, 8'h00, 2'b11, 10'b1010101011,  0}
    };
`endif

    #1;
    do_reset();

    foreach (vecs[i]) begin
      r = vecs[i].din[DIN_W-1:0];
      model_enc(vecs[i].de, expand(r), vecs[i].ctrl, s);
      step(vecs[i].de, r, vecs[i].ctrl, vecs[i].exp_tmds, vecs[i].exp_disp,
           $sformatf("vec%0d", i));
    end

    // long active line against the reference model
    for (int i = 0; i < 1366; i++) begin
      model_step(1'b1, DIN_W'($urandom_range(0, (1 << DIN_W) - 1)), 2'b00, "line");
      n_cmp++;
      if ($signed(disp) > 6'sd10 || $signed(disp) < -6'sd10) begin
        n_fail++;
        $display("FAIL disp bound: got %0d required |disp|<=10", $signed(disp));
      end
    end
    model_step(1'b0, '0, 2'b01, "blank0");
    model_step(1'b0, '0, 2'b01, "blank1");
    model_step(1'b0, '0, 2'b10, "blank2");
    check_int("disp zero on first ctrl", int'($signed(disp)), 0);

    // reset in the middle of active video discards the in-flight symbols
    model_step(1'b1, DIN_W'(8'hA7), 2'b00, "pre_rst0");
    model_step(1'b1, DIN_W'(8'h3C), 2'b00, "pre_rst1");
    do_reset();
    model_step(1'b1, '0, 2'b00, "post_rst0");
    model_step(1'b1, '0, 2'b00, "post_rst1");
    model_step(1'b1, '0, 2'b00, "post_rst2");
    model_step(1'b0, '0, 2'b00, "post_rst3");
    model_step(1'b0, '0, 2'b00, "post_rst4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Single-channel DVI 1.0 TMDS encoder for the display output path. It takes one 8-bit colour channel, two control bits and data-enable, all already in the pixel clock domain, and produces one 10-bit DC-balanced TMDS symbol per pixel clock. The output feeds the 10:1 serialiser. The board top instantiates three of these, one per channel (B, G, R), and drives `ch0_ctrl` with {vsync, hsync}.

## Interface
- `BPC`, default 5: input bits per channel. Used only when `ISLE_TMDS_EXPAND_EN` is defined. Legal range 4–7.
- `clk_pix` in 1: pixel clock; all logic on its rising edge.
- `rst_pix_n` in 1: reset, asynchronous assert, active-low.
- `de` in 1: data enable (active video).
- `din` in 8 (or `BPC` with `ISLE_TMDS_EXPAND_EN`): colour data; sampled only when `de`=1.
- `ctrl` in 2: control bits {c1, c0}; sampled only when `de`=0.
- `tmds` out 10: encoded symbol; bit 0 is transmitted first.
- `disp` out 6: signed running disparity (debug/verification).

## Operation
- Stage A, registered:
  - N1d = popcount(din).
  - If N1d>4 or (N1d==4 and din[0]==0), use XNOR: q_m[0]=d[0], q_m[i]=q_m[i-1] XNOR d[i], q_m[8]=0.
  - Otherwise use XOR with q_m[8]=1.
  - Also register N1q = popcount(q_m[7:0]), `de` and `ctrl`.
- Stage B, registered: N0q = 8−N1q; cnt is 6-bit signed. When de_A=1:
  - cnt==0 or N1q==N0q:
    - tmds = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m8 ? (N1q−N0q) : (N0q−N1q).
  - (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q):
    - tmds = {1, q_m8, ~q_m[7:0]}.
    - cnt += 2·q_m8 + (N0q−N1q).
  - Otherwise:
    - tmds = {0, q_m8, q_m[7:0]}.
    - cnt += (N1q−N0q) − 2·~q_m8.
- When de_A=0, cnt ← 0 and tmds is the control symbol:
  - 00 → 10'b1101010100
  - 01 → 10'b0010101011
  - 10 → 10'b0101010100
  - 11 → 10'b1010101011
- Arithmetic: all disparity maths is 6-bit signed, sign-extending the counts. |cnt| ≤ 10 by construction; no saturation logic is needed.
- `disp` equals the registered cnt.

## Timing
- Latency is 2 clk_pix cycles: inputs at edge k appear on `tmds` after edge k+2. Throughput is 1 symbol per cycle; no stalls and no handshake.
- Reset (async, `rst_pix_n`=0):
  - Stage A clears: de_A=0, ctrl_A=00, q_m=0, N1q=0.
  - tmds = 10'b1101010100 immediately.
  - cnt = 0, so disp = 0.
  - Takes effect without a clock edge.
- Reset release: first valid symbol from new inputs appears 2 edges later; before that, output holds the ctrl-00 symbol.
- de 1→0 transition: the first control symbol appears 2 cycles after the input edge, and cnt is zero on that same cycle.
- de 0→1 transition: the first data symbol is encoded from cnt=0.
- Reset asserted mid-line: the in-flight symbols are discarded. No partial symbol is ever output.

## Configuration
- `ISLE_TMDS_EXPAND_EN` defined:
  - `din` is BPC bits wide.
  - It is expanded to 8 bits before stage A by MSB replication: {din, din[BPC-1 -: 8−BPC]}. For BPC=5 this is {d,d[4:2]}, e.g. 5'h1F→8'hFF, 5'h10→8'h84.
  - The expansion is combinational, so latency is unchanged.
- Not defined: `din` is 8 bits and `BPC` is ignored.

## Structure
- Package `isle_tmds_pkg` holds:
  - `TMDS_W`=10
  - `TMDS_CNT_W`=6
  - the four control-symbol constants `TMDS_CTRL_00`..`TMDS_CTRL_11`
- Sub-module `tmds_qm` contains stage A: transition-minimisation, popcount, and the registered de/ctrl. The top module holds expansion and stage B.

## Test plan
- Reset: hold `rst_pix_n`=0 with random inputs → tmds=10'b1101010100 and disp=0 asynchronously; after release with de=0, ctrl=00, output is unchanged.
- Control symbols: de=0, ctrl=01, then 10, then 11 → 0010101011, 0101010100, 1010101011 each 2 cycles later; disp=0 throughout.
- Data balance from cnt=0: de=1, din=8'h00, 8'h00 → tmds=10'h100 (disp −8), then 10'h3FF (disp +2).
- XNOR path: after de=0, feed de=1, din=8'hFF → tmds=10'h200, disp=−8.
- Long line: 1366 random bytes with de=1, then de=0 → every symbol matches a reference model; |disp|≤10; disp returns to 0 on the first control symbol.
- Expansion (`ISLE_TMDS_EXPAND_EN`, BPC=5): din=5'h1F → same output as 8-bit build with 8'hFF; 5'h10 matches 8'h84.
